// File: rtl/time_of_day_counter_if.sv
// Time-of-day output bundle.
// Carries the binary seconds/minutes/hours produced by time_of_day_counter.
//   seconds : 7 bits, 0..59 (bit 6 always 0)
//   minutes : 6 bits, 0..59
//   hours   : 5 bits, 0..HOURS_PER_DAY-1
// Modports:
//   master : the counter, drives all three fields
//   slave  : a consumer (display / timestamp logic), reads all three fields
interface time_of_day_counter_if;
  logic [6:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;

  modport master (output seconds, output minutes, output hours);
  modport slave  (input  seconds, input  minutes, input  hours);
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour (parameterisable) time-of-day counter.
// A prescaler divides clk by TICKS_PER_SEC to form a one-second tick; the tick
// advances seconds, which cascade into minutes and hours within the same edge.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : asynchronous, active-high; clears time and prescaler phase
//   tod   : time_of_day_counter_if.master, registered seconds/minutes/hours
// Parameters:
//   TICKS_PER_SEC : clk edges per one-second advance (>= 1)
//   HOURS_PER_DAY : hour modulus (1..32)
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  time_of_day_counter_if.master         tod
);

  // Prescaler needs at least one bit even when it never counts.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);
  localparam logic [4:0]    HOUR_MAX = 5'(HOURS_PER_DAY - 1);

  logic [PW-1:0] presc_r;
  logic [6:0]    sec_r;
  logic [5:0]    min_r;
  logic [4:0]    hour_r;

  logic [PW-1:0] presc_nxt_s;
  logic [6:0]    sec_nxt_s;
  logic [5:0]    min_nxt_s;
  logic [4:0]    hour_nxt_s;
  logic          tick_s;
  logic          min_carry_s;
  logic          hour_carry_s;

  // Next-state logic: prescaler, then the seconds -> minutes -> hours carry chain.
  // Limits are compared with >= so a corrupted value falls back to 0 on its next
  // rollover instead of running through the unused code space.
  always_comb begin
    presc_nxt_s  = presc_r;
    sec_nxt_s    = sec_r;
    min_nxt_s    = min_r;
    hour_nxt_s   = hour_r;
    min_carry_s  = 1'b0;
    hour_carry_s = 1'b0;

    tick_s = (presc_r >= PRE_MAX);

    if (tick_s) begin
      presc_nxt_s = PRE_ZERO;
    end else begin
      presc_nxt_s = presc_r + PRE_ONE;
    end

    if (tick_s) begin
      if (sec_r >= 7'd59) begin
        sec_nxt_s   = 7'd0;
        min_carry_s = 1'b1;
      end else begin
        sec_nxt_s = sec_r + 7'd1;
      end
    end else begin
      sec_nxt_s = sec_r;
    end

    if (min_carry_s) begin
      if (min_r >= 6'd59) begin
        min_nxt_s    = 6'd0;
        hour_carry_s = 1'b1;
      end else begin
        min_nxt_s = min_r + 6'd1;
      end
    end else begin
      min_nxt_s = min_r;
    end

    if (hour_carry_s) begin
      if (hour_r >= HOUR_MAX) begin
        hour_nxt_s = 5'd0;
      end else begin
        hour_nxt_s = hour_r + 5'd1;
      end
    end else begin
      hour_nxt_s = hour_r;
    end
  end

  // State registers; reset discards both the time and the prescaler phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= PRE_ZERO;
      sec_r   <= 7'd0;
      min_r   <= 6'd0;
      hour_r  <= 5'd0;
    end else begin
      presc_r <= presc_nxt_s;
      sec_r   <= sec_nxt_s;
      min_r   <= min_nxt_s;
      hour_r  <= hour_nxt_s;
    end
  end

  assign tod.seconds = sec_r;
  assign tod.minutes = min_r;
  assign tod.hours   = hour_r;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench for time_of_day_counter.
// Four instances share one clock, each with its own reset so they are exercised
// one after another:
//   u_a : TICKS_PER_SEC=1, HOURS_PER_DAY=24 (reset, counting, rollovers, reset mid-run)
//   u_b : TICKS_PER_SEC=4, HOURS_PER_DAY=12 (prescaler phase and reset of phase)
//   u_c : TICKS_PER_SEC=1, HOURS_PER_DAY=3  (full day wrap in a short run)
//   u_d : TICKS_PER_SEC=3, HOURS_PER_DAY=1  (day wrap through a prescaler)
// Expected values are pushed to a scoreboard queue when stimulus is applied and
// popped/compared once the edges have been applied.
module tb_time_of_day_counter;

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;

  time_of_day_counter_if tod_a ();
  time_of_day_counter_if tod_b ();
  time_of_day_counter_if tod_c ();
  time_of_day_counter_if tod_d ();

  time_of_day_counter #(.TICKS_PER_SEC(1), .HOURS_PER_DAY(24)) u_a (.clk(clk), .reset(rst_a), .tod(tod_a));
  time_of_day_counter #(.TICKS_PER_SEC(4), .HOURS_PER_DAY(12)) u_b (.clk(clk), .reset(rst_b), .tod(tod_b));
  time_of_day_counter #(.TICKS_PER_SEC(1), .HOURS_PER_DAY(3))  u_c (.clk(clk), .reset(rst_c), .tod(tod_c));
  time_of_day_counter #(.TICKS_PER_SEC(3), .HOURS_PER_DAY(1))  u_d (.clk(clk), .reset(rst_d), .tod(tod_d));

  typedef struct {
    string      name;
    int         unit;
    logic [6:0] s;
    logic [5:0] m;
    logic [4:0] h;
  } exp_t;

  typedef struct {
    string      name;
    int         edges;
    logic [6:0] s;
    logic [5:0] m;
    logic [4:0] h;
  } vec_t;

  exp_t sb_q[$];
  vec_t va[6];
  int   tests_run;
  int   tests_failed;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Current output of the selected instance packed as {h, m, s}.
  function automatic logic [17:0] read_unit(input int unit);
    case (unit)
      0:       return {tod_a.hours, tod_a.minutes, tod_a.seconds};
      1:       return {tod_b.hours, tod_b.minutes, tod_b.seconds};
      2:       return {tod_c.hours, tod_c.minutes, tod_c.seconds};
      3:       return {tod_d.hours, tod_d.minutes, tod_d.seconds};
      default: return 18'h3ffff;
    endcase
  endfunction

  // Apply 'edges' rising edges and settle #1 after the last; 0 edges just settles.
  task automatic advance(input int edges);
    if (edges == 0) begin
      #1;
    end else begin
      repeat (edges) @(posedge clk);
      #1;
    end
  endtask

  // Push the expectation, apply the stimulus, then pop and compare.
  task automatic step(input int unit, input int edges, input string name,
                      input logic [4:0] h, input logic [5:0] m, input logic [6:0] s);
    exp_t e;
    logic [17:0] got;
    e.name = name; e.unit = unit; e.h = h; e.m = m; e.s = s;
    sb_q.push_back(e);
    advance(edges);
    e = sb_q.pop_front();
    got = read_unit(e.unit);
    tests_run++;
    if (got !== {e.h, e.m, e.s}) begin
      tests_failed++;
      $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d", e.name,
               got[17:13], got[12:7], got[6:0], e.h, e.m, e.s);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    // Edge counts are incremental from the previous table row.
    va[0] = '{"a_45s",     45,   7'd45, 6'd0,  5'd0};
    va[1] = '{"a_59s",     14,   7'd59, 6'd0,  5'd0};
    va[2] = '{"a_min_roll", 1,   7'd0,  6'd1,  5'd0};
    va[3] = '{"a_hour_1",  3540, 7'd0,  6'd0,  5'd1};
    va[4] = '{"a_1_59_59", 3599, 7'd59, 6'd59, 5'd1};
    va[5] = '{"a_hour_2",  1,    7'd0,  6'd0,  5'd2};

    // Reset held with clk running.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, "a_reset_hold", 5'd0, 6'd0, 7'd0);
    end

    // Released 1 unit after an edge; the next edge is the first counting edge.
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, va[i].edges, va[i].name, va[i].h, va[i].m, va[i].s);
    end

    // Reset mid-operation: restart, run to 00:02:17, hold reset 3 cycles.
    rst_a = 1'b1;
    step(0, 0, "a_async_clear", 5'd0, 6'd0, 7'd0);
    rst_a = 1'b0;
    step(0, 137, "a_2_17", 5'd0, 6'd2, 7'd17);
    rst_a = 1'b1;
    step(0, 0, "a_rst_immediate", 5'd0, 6'd0, 7'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, "a_rst_held", 5'd0, 6'd0, 7'd0);
    end
    rst_a = 1'b0;
    step(0, 0, "a_rst_released", 5'd0, 6'd0, 7'd0);
    step(0, 1, "a_first_after_rst", 5'd0, 6'd0, 7'd1);

    // Reset asserted between edges must clear before the next edge.
    step(0, 20, "a_pre_async", 5'd0, 6'd0, 7'd21);
    @(negedge clk);
    rst_a = 1'b1;
    step(0, 0, "a_async_mid_cycle", 5'd0, 6'd0, 7'd0);

    // Prescaler: seconds stays 0 for edges 1-3 and becomes 1 on edge 4.
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step(1, 1, "b_presc_hold", 5'd0, 6'd0, 7'd0);
    end
    step(1, 1, "b_presc_edge4", 5'd0, 6'd0, 7'd1);
    step(1, 4, "b_presc_edge8", 5'd0, 6'd0, 7'd2);
    step(1, 232, "b_minute", 5'd0, 6'd1, 7'd0);
    // Reset part-way through a prescaler period discards the phase.
    step(1, 2, "b_mid_phase", 5'd0, 6'd1, 7'd0);
    rst_b = 1'b1;
    step(1, 0, "b_rst_clear", 5'd0, 6'd0, 7'd0);
    rst_b = 1'b0;
    step(1, 3, "b_phase_fresh", 5'd0, 6'd0, 7'd0);
    step(1, 1, "b_phase_edge4", 5'd0, 6'd0, 7'd1);

    // Day wrap with 3 hours per day: 02:59:59 -> 00:00:00 in one edge.
    rst_c = 1'b0;
    step(2, 10799, "c_day_last", 5'd2, 6'd59, 7'd59);
    step(2, 1, "c_day_wrap", 5'd0, 6'd0, 7'd0);
    step(2, 1, "c_after_wrap", 5'd0, 6'd0, 7'd1);

    // Day wrap through a divide-by-3 prescaler with a single hour per day.
    rst_d = 1'b0;
    step(3, 10799, "d_day_last", 5'd0, 6'd59, 7'd59);
    step(3, 1, "d_day_wrap", 5'd0, 6'd0, 7'd0);
    step(3, 2, "d_wrap_hold", 5'd0, 6'd0, 7'd0);
    step(3, 1, "d_after_wrap", 5'd0, 6'd0, 7'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
